// File: rtl/trig_arb_pkg.sv
// Shared types and default sizing for the L1 trigger arbiter.
package trig_arb_pkg;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned PEND_W  = 3;
   localparam int unsigned ID_W    = 5;
   localparam int unsigned GAP_CYC = 2;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BURST = 2'd2,
      GAP   = 2'd3
   } state_e;

endpackage

// File: rtl/trigger_arbiter_if.sv
// Request/trigger bus between the request sources and the arbiter.
interface trigger_arbiter_if #(
   parameter int unsigned NUM_REQ = trig_arb_pkg::NUM_REQ,
   parameter int unsigned CNT_W   = trig_arb_pkg::CNT_W,
   parameter int unsigned PEND_W  = trig_arb_pkg::PEND_W,
   parameter int unsigned ID_W    = trig_arb_pkg::ID_W,
   parameter int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

   logic [NUM_REQ-1:0]        Req;
   logic [NUM_REQ-1:0]        Req_Enable;
   logic [CNT_W-1:0]          Trigger_Count;
   logic                      L1_Reg_Full;
   logic                      Trig_Out;
   logic [SRC_W-1:0]          Trig_Src;
   logic [ID_W-1:0]           L1_ID;
   logic                      Busy;
   logic [NUM_REQ*PEND_W-1:0] Pending;
   logic                      Drop;
   logic [7:0]                Drop_Count;

   modport master (
      output Req, Req_Enable, Trigger_Count, L1_Reg_Full,
      input  Trig_Out, Trig_Src, L1_ID, Busy, Pending, Drop, Drop_Count
   );

   modport slave (
      input  Req, Req_Enable, Trigger_Count, L1_Reg_Full,
      output Trig_Out, Trig_Src, L1_ID, Busy, Pending, Drop, Drop_Count
   );

endinterface

// File: rtl/trig_pend_counter.sv
// Per-source pending-request counter: saturating up/down with flush.
module trig_pend_counter #(
   parameter int unsigned W = trig_arb_pkg::PEND_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   input  logic         flush,
   output logic [W-1:0] count,
   output logic         drop_c
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] count_q, count_d;

   // Simultaneous inc and dec cancel, so a full counter still accepts that request.
   always_comb begin
      count_d = count_q;
      drop_c  = 1'b0;
      if (flush) begin
         count_d = '0;
      end else if (inc && !dec) begin
         if (count_q == CNT_MAX) drop_c = 1'b1;
         else                    count_d = count_q + W'(1);
      end else if (dec && !inc && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/trigger_arbiter.sv
// Merges buffered L1 requests by fixed priority into one paced trigger stream
// with source tag, L1 ID and drop accounting.
module trigger_arbiter
   import trig_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = trig_arb_pkg::NUM_REQ,
   parameter int unsigned CNT_W   = trig_arb_pkg::CNT_W,
   parameter int unsigned PEND_W  = trig_arb_pkg::PEND_W,
   parameter int unsigned ID_W    = trig_arb_pkg::ID_W,
   parameter int unsigned GAP_CYC = trig_arb_pkg::GAP_CYC
) (
   input logic              Clk,
   input logic              Reset,
   trigger_arbiter_if.slave bus
);

   localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SUM_W = 9;

   logic [PEND_W-1:0]         pend [NUM_REQ];
   logic [NUM_REQ-1:0]        inc_c, flush_c, dec_c, drop_c;
   logic [NUM_REQ*PEND_W-1:0] pend_flat_c;
   logic                      any_pend_c;
   logic [SRC_W-1:0]          pick_c;
   logic [SUM_W-1:0]          drop_sum_c;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trig_out_q, trig_out_d;
   logic [SRC_W-1:0] trig_src_q, trig_src_d;
   logic [ID_W-1:0]  l1_id_q, l1_id_d;
   logic             busy_q, busy_d;
   logic             drop_q, drop_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   assign inc_c   = bus.Req & bus.Req_Enable;
   assign flush_c = ~bus.Req_Enable;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_pend
      trig_pend_counter #(.W(PEND_W)) u_pend (
         .clk    (Clk),
         .rst    (Reset),
         .inc    (inc_c[i]),
         .dec    (dec_c[i]),
         .flush  (flush_c[i]),
         .count  (pend[i]),
         .drop_c (drop_c[i])
      );
   end

   // Priority pick (lowest index wins) and consume of the issued source.
   always_comb begin
      pend_flat_c = '0;
      any_pend_c  = 1'b0;
      pick_c      = '0;
      dec_c       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pend_flat_c[i*PEND_W +: PEND_W] = pend[i];
         if (!any_pend_c && (pend[i] != '0)) begin
            any_pend_c = 1'b1;
            pick_c     = SRC_W'(i);
         end
         dec_c[i] = (state_q == ISSUE) && (trig_src_q == SRC_W'(i));
      end
   end

   always_comb begin
      drop_sum_c = SUM_W'(drop_cnt_q);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         drop_sum_c = drop_sum_c + SUM_W'(drop_c[i]);
      end
   end

   // cnt_q counts the burst in BURST and is reused for the guard gap in GAP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      trig_out_d = 1'b0;
      trig_src_d = trig_src_q;
      l1_id_d    = l1_id_q;
      case (state_q)
         IDLE: begin
            if (any_pend_c && !bus.L1_Reg_Full) begin
               state_d    = ISSUE;
               trig_out_d = 1'b1;
               trig_src_d = pick_c;
               l1_id_d    = l1_id_q + ID_W'(1);
            end
         end
         ISSUE: begin
            state_d = BURST;
            cnt_d   = (bus.Trigger_Count == '0) ? CNT_W'(1) : bus.Trigger_Count;
         end
         BURST: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = GAP;
               cnt_d   = CNT_W'(GAP_CYC);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d     = (state_d != IDLE);
      drop_d     = |drop_c;
      drop_cnt_d = (drop_sum_c > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum_c[7:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         trig_out_q <= 1'b0;
         trig_src_q <= '0;
         l1_id_q    <= '0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         trig_out_q <= trig_out_d;
         trig_src_q <= trig_src_d;
         l1_id_q    <= l1_id_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.Trig_Out   = trig_out_q;
   assign bus.Trig_Src   = trig_src_q;
   assign bus.L1_ID      = l1_id_q;
   assign bus.Busy       = busy_q;
   assign bus.Pending    = pend_flat_c;
   assign bus.Drop       = drop_q;
   assign bus.Drop_Count = drop_cnt_q;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Bench for trigger_arbiter: cycle table, directed corner sequences and a
// randomized run, all checked against a schedule-based reference model.
module tb_trigger_arbiter;
   import trig_arb_pkg::*;

   localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PMAX   = (1 << PEND_W) - 1;
   localparam int ID_MOD = 1 << ID_W;
   localparam int NVEC   = 21;

   logic clk;
   logic rst;

   trigger_arbiter_if bus ();
   trigger_arbiter dut (.Clk(clk), .Reset(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int trig_seen = 0;

   // Reference model: pending counts plus a time schedule of when the
   // arbiter is next free to decide.
   int m_cyc = 0;
   int m_idle_from = 0;
   int m_issue_at = -1;
   int m_pend [NUM_REQ];
   int m_src, m_id, m_dcnt;
   bit m_trig, m_busy, m_drop;

   typedef struct {
      logic                      rst;
      logic [NUM_REQ-1:0]        req;
      logic [NUM_REQ-1:0]        en;
      logic [CNT_W-1:0]          tc;
      logic                      full;
      logic                      trig;
      logic [SRC_W-1:0]          src;
      logic [ID_W-1:0]           id;
      logic                      busy;
      logic [NUM_REQ*PEND_W-1:0] pend;
      logic [7:0]                dcnt;
   } vec_t;

   vec_t tbl [NVEC];
   int   e_cyc [$];
   int   e_src [$];

   function automatic vec_t mk(logic r, logic [NUM_REQ-1:0] rq, logic [NUM_REQ-1:0] en,
                               logic [CNT_W-1:0] tc, logic fl, logic tr, logic [SRC_W-1:0] src,
                               logic [ID_W-1:0] id, logic bz, logic [NUM_REQ*PEND_W-1:0] pd,
                               logic [7:0] dc);
      vec_t v;
      v.rst = r; v.req = rq; v.en = en; v.tc = tc; v.full = fl;
      v.trig = tr; v.src = src; v.id = id; v.busy = bz; v.pend = pd; v.dcnt = dc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_edge(logic r, logic [NUM_REQ-1:0] rq, logic [NUM_REQ-1:0] en,
                                      logic [CNT_W-1:0] tc, logic fl);
      int  np [NUM_REQ];
      int  c, nd, first;
      bit  idle_now, issue_now, go;
      c = m_cyc;
      if (r) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_trig = 0; m_src = 0; m_id = 0; m_busy = 0; m_drop = 0; m_dcnt = 0;
         m_issue_at = -1;
         m_idle_from = c + 1;
         m_cyc = c + 1;
         return;
      end
      idle_now  = (c >= m_idle_from);
      issue_now = (c == m_issue_at);
      nd = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!en[i]) begin
            np[i] = 0;
         end else begin
            np[i] = m_pend[i] + int'(rq[i]) - ((issue_now && m_src == i) ? 1 : 0);
            if (np[i] > PMAX) begin
               np[i] = PMAX;
               nd++;
            end
            if (np[i] < 0) np[i] = 0;
         end
      end
      first = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (m_pend[i] != 0) first = i;
      go = idle_now && (first >= 0) && !fl;
      if (issue_now)
         m_idle_from = c + ((tc == 0) ? 1 : int'(tc)) + int'(GAP_CYC) + 1;
      if (go) begin
         m_src = first;
         m_id = (m_id + 1) % ID_MOD;
         m_issue_at = c + 1;
         m_idle_from = 32'h7fff_ffff;
      end
      m_trig = go;
      m_busy = (c + 1) < m_idle_from;
      m_drop = (nd > 0);
      m_dcnt = (m_dcnt + nd > 255) ? 255 : m_dcnt + nd;
      m_pend = np;
      m_cyc = c + 1;
   endfunction

   // One clock: capture inputs, advance DUT and model, compare every output.
   task automatic step();
      logic r, fl;
      logic [NUM_REQ-1:0] rq, en;
      logic [CNT_W-1:0] tc;
      r = rst; rq = bus.Req; en = bus.Req_Enable; tc = bus.Trigger_Count; fl = bus.L1_Reg_Full;
      @(posedge clk);
      #1;
      model_edge(r, rq, en, tc, fl);
      if (bus.Trig_Out === 1'b1) trig_seen++;
      chk("mdl_trig", 32'(bus.Trig_Out), 32'(m_trig));
      chk("mdl_src", 32'(bus.Trig_Src), 32'(m_src));
      chk("mdl_id", 32'(bus.L1_ID), 32'(m_id));
      chk("mdl_busy", 32'(bus.Busy), 32'(m_busy));
      chk("mdl_drop", 32'(bus.Drop), 32'(m_drop));
      chk("mdl_dcnt", 32'(bus.Drop_Count), 32'(m_dcnt));
      for (int i = 0; i < NUM_REQ; i++)
         chk($sformatf("mdl_pend%0d", i), 32'(bus.Pending[i*PEND_W +: PEND_W]), 32'(m_pend[i]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.Req = '0; bus.Req_Enable = '1; bus.Trigger_Count = CNT_W'(4); bus.L1_Reg_Full = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t0, w, k;
      rst = 1'b1;
      bus.Req = '0; bus.Req_Enable = '1; bus.Trigger_Count = CNT_W'(4); bus.L1_Reg_Full = 1'b0;

      // Single request with 4-cycle burst, then enable flush and zero-length burst.
      tbl[0]  = mk(1, 3'b000, 3'b111, 4'd4, 0, 0, 0, 0, 0, 9'h000, 0);
      tbl[1]  = mk(0, 3'b010, 3'b111, 4'd4, 0, 0, 0, 0, 0, 9'h008, 0);
      tbl[2]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 1, 1, 1, 1, 9'h008, 0);
      tbl[3]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 1, 9'h000, 0);
      tbl[4]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 1, 9'h000, 0);
      tbl[5]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 1, 9'h000, 0);
      tbl[6]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 1, 9'h000, 0);
      tbl[7]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 1, 9'h000, 0);
      tbl[8]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 1, 9'h000, 0);
      tbl[9]  = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 0, 9'h000, 0);
      tbl[10] = mk(0, 3'b010, 3'b111, 4'd4, 1, 0, 1, 1, 0, 9'h008, 0);
      tbl[11] = mk(0, 3'b010, 3'b111, 4'd4, 1, 0, 1, 1, 0, 9'h010, 0);
      tbl[12] = mk(0, 3'b010, 3'b111, 4'd4, 1, 0, 1, 1, 0, 9'h018, 0);
      tbl[13] = mk(0, 3'b010, 3'b101, 4'd4, 1, 0, 1, 1, 0, 9'h000, 0);
      tbl[14] = mk(0, 3'b000, 3'b111, 4'd4, 0, 0, 1, 1, 0, 9'h000, 0);
      tbl[15] = mk(0, 3'b001, 3'b111, 4'd0, 0, 0, 1, 1, 0, 9'h001, 0);
      tbl[16] = mk(0, 3'b000, 3'b111, 4'd0, 0, 1, 0, 2, 1, 9'h001, 0);
      tbl[17] = mk(0, 3'b000, 3'b111, 4'd0, 0, 0, 0, 2, 1, 9'h000, 0);
      tbl[18] = mk(0, 3'b000, 3'b111, 4'd0, 0, 0, 0, 2, 1, 9'h000, 0);
      tbl[19] = mk(0, 3'b000, 3'b111, 4'd0, 0, 0, 0, 2, 1, 9'h000, 0);
      tbl[20] = mk(0, 3'b000, 3'b111, 4'd0, 0, 0, 0, 2, 0, 9'h000, 0);

      for (int v = 0; v < NVEC; v++) begin
         rst = tbl[v].rst; bus.Req = tbl[v].req; bus.Req_Enable = tbl[v].en;
         bus.Trigger_Count = tbl[v].tc; bus.L1_Reg_Full = tbl[v].full;
         step();
         chk($sformatf("tbl%0d_trig", v), 32'(bus.Trig_Out), 32'(tbl[v].trig));
         chk($sformatf("tbl%0d_src", v), 32'(bus.Trig_Src), 32'(tbl[v].src));
         chk($sformatf("tbl%0d_id", v), 32'(bus.L1_ID), 32'(tbl[v].id));
         chk($sformatf("tbl%0d_busy", v), 32'(bus.Busy), 32'(tbl[v].busy));
         chk($sformatf("tbl%0d_pend", v), 32'(bus.Pending), 32'(tbl[v].pend));
         chk($sformatf("tbl%0d_dcnt", v), 32'(bus.Drop_Count), 32'(tbl[v].dcnt));
      end
      rst = 1'b0;

      // Two sources in one cycle: src 0 first, src 2 exactly 8 cycles later.
      do_reset();
      bus.Req = 3'b101;
      step();
      bus.Req = '0;
      chk("t2_pend_both", 32'(bus.Pending), 32'h041);
      for (int c = 1; c <= 30; c++) begin
         step();
         if (bus.Trig_Out === 1'b1) begin
            e_cyc.push_back(c);
            e_src.push_back(int'(bus.Trig_Src));
         end
      end
      chk("t2_npulse", 32'(e_cyc.size()), 2);
      chk("t2_latency", (e_cyc.size() > 0) ? 32'(e_cyc[0]) : 32'hFFFF, 1);
      chk("t2_src_a", (e_src.size() > 0) ? 32'(e_src[0]) : 32'hFFFF, 0);
      chk("t2_src_b", (e_src.size() > 1) ? 32'(e_src[1]) : 32'hFFFF, 2);
      chk("t2_spacing", (e_cyc.size() > 1) ? 32'(e_cyc[1] - e_cyc[0]) : 32'hFFFF, 8);

      // Held off by L1_Reg_Full: 9 requests leave 7 pending and 2 drops.
      do_reset();
      t0 = trig_seen;
      bus.L1_Reg_Full = 1'b1;
      bus.Req = 3'b001;
      repeat (9) step();
      bus.Req = '0;
      step();
      chk("t3_pend_max", 32'(bus.Pending[PEND_W-1:0]), 7);
      chk("t3_dcnt", 32'(bus.Drop_Count), 2);
      chk("t3_no_trig", 32'(trig_seen - t0), 0);
      t0 = trig_seen;
      bus.L1_Reg_Full = 1'b0;
      repeat (100) step();
      chk("t3_issues", 32'(trig_seen - t0), 7);
      chk("t3_pend_empty", 32'(bus.Pending), 0);

      // L1_Reg_Full and Trigger_Count changes mid-burst leave the burst intact.
      do_reset();
      bus.Trigger_Count = CNT_W'(6);
      bus.Req = 3'b010;
      step();
      bus.Req = '0;
      step();
      chk("t4_issue", 32'(bus.Trig_Out), 1);
      step();
      bus.L1_Reg_Full = 1'b1;
      bus.Trigger_Count = CNT_W'(1);
      w = 0;
      do begin
         step();
         w++;
      end while (bus.Busy === 1'b1 && w < 30);
      chk("t4_busy_len", 32'(w), 8);

      // Reset while a burst is running.
      bus.L1_Reg_Full = 1'b0;
      bus.Trigger_Count = CNT_W'(5);
      bus.Req = 3'b001;
      step();
      bus.Req = 3'b100;
      step();
      bus.Req = '0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_rst_trig", 32'(bus.Trig_Out), 0);
      chk("t4_rst_busy", 32'(bus.Busy), 0);
      chk("t4_rst_id", 32'(bus.L1_ID), 0);
      chk("t4_rst_src", 32'(bus.Trig_Src), 0);
      chk("t4_rst_pend", 32'(bus.Pending), 0);

      // 33 issues wrap the L1 ID through zero.
      do_reset();
      bus.Trigger_Count = '0;
      for (k = 1; k <= 33; k++) begin
         bus.Req = 3'b001;
         step();
         bus.Req = '0;
         w = 0;
         while (bus.Trig_Out !== 1'b1 && w < 10) begin
            step();
            w++;
         end
         chk("t6_trig_wait", 32'(bus.Trig_Out), 1);
         if (k == 32) chk("t6_id_wrap", 32'(bus.L1_ID), 0);
         w = 0;
         while (bus.Busy === 1'b1 && w < 20) begin
            step();
            w++;
         end
      end
      chk("t6_id_final", 32'(bus.L1_ID), 1);

      // Increment and decrement of a full counter in the same cycle.
      do_reset();
      bus.L1_Reg_Full = 1'b1;
      bus.Req = 3'b001;
      repeat (7) step();
      bus.Req = '0;
      bus.L1_Reg_Full = 1'b0;
      step();
      chk("t6_issue_at_max", 32'(bus.Trig_Out), 1);
      bus.Req = 3'b001;
      step();
      bus.Req = '0;
      chk("t6_incdec_pend", 32'(bus.Pending[PEND_W-1:0]), 7);
      chk("t6_incdec_drop", 32'(bus.Drop), 0);
      chk("t6_incdec_dcnt", 32'(bus.Drop_Count), 0);

      // Multiple drops per cycle and Drop_Count saturation.
      do_reset();
      bus.L1_Reg_Full = 1'b1;
      bus.Req = 3'b111;
      repeat (7) step();
      chk("sat_no_drop_yet", 32'(bus.Drop_Count), 0);
      step();
      chk("sat_drop_pulse", 32'(bus.Drop), 1);
      chk("sat_triple_drop", 32'(bus.Drop_Count), 3);
      repeat (85) step();
      chk("sat_dcnt_255", 32'(bus.Drop_Count), 255);
      bus.Req = '0;
      step();
      chk("sat_drop_low", 32'(bus.Drop), 0);
      chk("sat_dcnt_hold", 32'(bus.Drop_Count), 255);

      // Randomized traffic with occasional reset, checked cycle by cycle.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            bus.Req[i]        = ($urandom_range(0, 3) == 0);
            bus.Req_Enable[i] = ($urandom_range(0, 15) != 0);
         end
         bus.Trigger_Count = CNT_W'($urandom_range(0, 6));
         bus.L1_Reg_Full   = ($urandom_range(0, 5) == 0);
         rst               = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
